// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer and a registered one-hot grant.
// Optional per-owner hold timeout is compiled in with `define RR_ARB_TIMEOUT_EN.
module ring_rr_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id,
    output logic [N-1:0]         ptr
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_grant;
    logic [N-1:0] r_ptr;
    logic [N-1:0] w_grant_nxt;
    logic [N-1:0] w_ptr_nxt;
    logic [N-1:0] w_arb_req;
    logic [N-1:0] w_win_oh;
    logic [N-1:0] w_win_rot;
    logic         w_win_found;
    logic         w_owner_req;
    logic         w_timeout;
    int unsigned  w_ptr_idx;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int unsigned    HW        = $clog2(HOLD_MAX);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_MAX - 1);
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nxt;
`endif

    assign w_owner_req = |(req & r_grant);

`ifdef RR_ARB_TIMEOUT_EN
    assign w_timeout = (r_state == GRANT) && w_owner_req && (r_hold == HOLD_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // On a forced handover the current owner is excluded from the search.
    always_comb begin
        w_arb_req = req;
        if (w_timeout) begin
            w_arb_req = req & ~r_grant;
        end
    end

    always_comb begin
        int unsigned idx;
        idx         = 0;
        w_ptr_idx   = 0;
        w_win_oh    = '0;
        w_win_found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (r_ptr[i]) begin
                w_ptr_idx = i;
            end
        end
        for (int unsigned k = 0; k < N; k++) begin
            idx = (w_ptr_idx + k) % N;
            if (!w_win_found && w_arb_req[idx]) begin
                w_win_oh[idx] = 1'b1;
                w_win_found   = 1'b1;
            end
        end
    end

    assign w_win_rot = {w_win_oh[N-2:0], w_win_oh[N-1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= N'(1);
`ifdef RR_ARB_TIMEOUT_EN
            r_hold  <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
`ifdef RR_ARB_TIMEOUT_EN
            r_hold  <= w_hold_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_win_found) begin
                    w_state_nxt = GRANT;
                    w_grant_nxt = w_win_oh;
                    w_ptr_nxt   = w_win_rot;
                end
            end
            GRANT: begin
                if (!w_owner_req) begin
                    if (w_win_found) begin
                        w_grant_nxt = w_win_oh;
                        w_ptr_nxt   = w_win_rot;
                    end else begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                    end
                end else if (w_timeout && w_win_found) begin
                    w_grant_nxt = w_win_oh;
                    w_ptr_nxt   = w_win_rot;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

`ifdef RR_ARB_TIMEOUT_EN
    // Counts only uninterrupted holds; any owner change or expiry restarts it.
    always_comb begin
        w_hold_nxt = '0;
        if ((r_state == GRANT) && w_owner_req && !w_timeout) begin
            w_hold_nxt = r_hold + 1'b1;
        end
    end
`endif

    always_comb begin
        grant       = r_grant;
        ptr         = r_ptr;
        grant_valid = |r_grant;
        grant_id    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (r_grant[i]) begin
                grant_id = i[$clog2(N)-1:0];
            end
        end
    end

endmodule
